// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN       = 32;
  localparam int ITERATIONS = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  function automatic logic a_signed(funct3_e f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic b_signed(funct3_e f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issuing stage and the muldiv unit.
interface muldiv_if;
  import muldiv_pkg::*;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, input busy, done, result);
  modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module muldiv_divstep
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_dvsr,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  // When the divisor fits, the true difference is below 2^XLEN, so the low bits suffice.
  assign w_diff  = w_shift[XLEN-1:0] - i_dvsr;
  assign o_qbit  = (w_shift >= {1'b0, i_dvsr});
  assign o_rem   = o_qbit ? w_diff : w_shift[XLEN-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: fixed 32-cycle run, shift-add multiply, restoring divide.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  state_e          r_state;
  logic [4:0]      r_cnt;
  funct3_e         r_f3;
  logic [XLEN-1:0] r_a, r_b;
  logic [63:0]     r_acc, r_mcand;
  logic [XLEN-1:0] r_mplier, r_rem, r_quo, r_dvsr;
  logic            r_busy, r_done;
  logic [XLEN-1:0] r_result;

  funct3_e         w_f3_in;
  logic            w_a_sgn_in, w_b_sgn_in, w_a_neg, w_b_neg, w_div_zero, w_qbit;
  logic [XLEN-1:0] w_rem_nxt, w_quo_fin, w_res;
  logic [63:0]     w_acc_nxt, w_prod;

  assign w_f3_in    = funct3_e'(bus.funct3);
  assign w_a_sgn_in = a_signed(w_f3_in) & bus.op_a[XLEN-1];
  assign w_b_sgn_in = b_signed(w_f3_in) & bus.op_b[XLEN-1];
  assign w_a_neg    = a_signed(r_f3) & r_a[XLEN-1];
  assign w_b_neg    = b_signed(r_f3) & r_b[XLEN-1];
  assign w_div_zero = (r_b == '0);

  // Only the low 32 multiplier bits are iterated; a negative B's bit-32 weight (-2^32)
  // is folded in as a single subtraction of A<<32 on the final iteration.
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
  assign w_prod     = w_acc_nxt - (w_b_neg ? {r_mcand[62:0], 1'b0} : 64'd0);

  muldiv_divstep u_divstep (
    .i_rem  (r_rem),
    .i_bit  (r_quo[XLEN-1]),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );
  assign w_quo_fin = {r_quo[XLEN-2:0], w_qbit};

  always_comb begin
    w_res = w_prod[XLEN-1:0];
    case (r_f3)
      F3_MULH, F3_MULHSU, F3_MULHU: w_res = w_prod[63:32];
      F3_DIV:  w_res = w_div_zero ? '1 : ((w_a_neg ^ w_b_neg) ? -w_quo_fin : w_quo_fin);
      F3_DIVU: w_res = w_quo_fin;
      F3_REM:  w_res = w_div_zero ? r_a : (w_a_neg ? -w_rem_nxt : w_rem_nxt);
      F3_REMU: w_res = w_rem_nxt;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= F3_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_f3     <= w_f3_in;
            r_a      <= bus.op_a;
            r_b      <= bus.op_b;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{32{w_a_sgn_in}}, bus.op_a};
            r_mplier <= bus.op_b;
            r_rem    <= '0;
            r_quo    <= w_a_sgn_in ? -bus.op_a : bus.op_a;
            r_dvsr   <= w_b_sgn_in ? -bus.op_b : bus.op_b;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_cnt    <= r_cnt + 5'd1;
          r_acc    <= w_acc_nxt;
          r_mcand  <= {r_mcand[62:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          r_rem    <= w_rem_nxt;
          r_quo    <= w_quo_fin;
          if (r_cnt == 5'(ITERATIONS - 1)) begin
            r_result <= w_res;
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus randomized ops vs a longint model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  muldiv_if bus ();

  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       nm;
  } exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int run_busy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          p;
    longint unsigned pu;
    case (f)
      3'd0: begin pu = ua * ub; return pu[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; pu = ua / ub; return pu[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; pu = ua % ub; return pu[31:0]; end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) run_busy = 0;
    else begin
      if (bus.busy) run_busy++;
      if (bus.done) begin
        if (sb_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk({e.nm, "_result"}, bus.result, e.res);
          chk({e.nm, "_latency"}, 32'(cyc), 32'(e.cyc));
          chk({e.nm, "_busy_cycles"}, 32'(run_busy), 32'd33);
        end
        run_busy = 0;
      end
    end
  end

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
    e.res = ref_op(f, a, b); e.cyc = cyc + 33; e.nm = nm;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(nm);
    @(posedge clk); #1;
    chk({nm, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("mul_neg",    3'd0, 32'd7,          32'hFFFF_FFFD);
    do_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000);
    do_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div_neg",    3'd4, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_neg",    3'd6, 32'hFFFF_FFF9, 32'd2);
    do_op("divu_zero",  3'd5, 32'd5,          32'd0);
    do_op("remu_zero",  3'd7, 32'd5,          32'd0);
    do_op("div_zero",   3'd4, 32'hFFFF_FFF9, 32'd0);
    do_op("rem_zero",   3'd6, 32'hFFFF_FFF9, 32'd0);
    do_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start held high with changing operands throughout the run must be ignored.
    begin
      exp_t e;
      bit seen = 0;
      bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7;
      e.res = 32'd14; e.cyc = cyc + 33; e.nm = "divu_busy_start";
      sb_q.push_back(e);
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (bus.done) seen = 1;
        else begin
          @(posedge clk); #1;
          bus.funct3 = 3'($urandom_range(0, 7)); bus.op_a = $urandom; bus.op_b = $urandom;
        end
      end
      bus.start = 1'b0;
      if (!seen) chk("divu_busy_start_timeout", 32'd0, 32'd1);
      repeat (40) @(posedge clk);
      #1;
    end

    // Reset at RUN iteration 10 aborts the operation without a done pulse.
    begin
      bit seen = 0;
      bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_result", bus.result, 32'd0);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.done) seen = 1;
      end
      chk("abort_no_done", {31'd0, seen}, 32'd0);
      @(posedge clk); #1;
    end

    do_op("mul_after_rst", 3'd0, 32'd3, 32'd4);

    for (int n = 0; n < 40; n++)
      do_op("rand", 3'($urandom_range(0, 7)), pick(), pick());

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
